if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage_pc_reg.sv | 35 +++
 rtl/if_stage.sv | 63 ++++++
 tb/tb_if_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, reset PC
// default, the IF/ID pipeline record and the PC increment helper.
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // Wraps modulo 2^32 by construction of the 32-bit result.
  function automatic logic [31:0] pc_plus4(input logic [31:0] p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Fetch program counter with next-PC selection: redirect, then stall hold,
// then sequential advance.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_p0;
  logic [31:0] target;

  // Low two bits of the target are dropped silently; fetch is word aligned.
  assign target = redirect_pc & ~32'h0000_0003;

  // Stage 0: fetch PC register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p0 <= RESET_PC;
    end else if (redirect_en) begin
      pc_p0 <= target;
    end else if (!stall) begin
      pc_p0 <= pc_plus4(pc_p0);
    end
  end

  assign pc = pc_p0;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the external instruction memory from the PC
// and captures the fetched word into the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_en,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic [31:0]        if_id_instr,
  output logic               if_id_valid
);

  logic [31:0] pc4;
  if_id_t      if_id_p1;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .pc         (pc)
  );

  assign pc4       = pc_plus4(pc);
  assign imem_addr = pc[IMEM_AW+1:2];

  // Stage 1: IF/ID register; a redirect squashes the wrong-path fetch even under stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id_p1 <= '0;
    end else if (redirect_en || flush) begin
      if_id_p1.pc    <= pc;
      if_id_p1.pc4   <= pc4;
      if_id_p1.instr <= NOP_INSTR;
      if_id_p1.valid <= 1'b0;
    end else if (!stall) begin
      if_id_p1.pc    <= pc;
      if_id_p1.pc4   <= pc4;
      if_id_p1.instr <= imem_rdata;
      if_id_p1.valid <= 1'b1;
    end
  end

  assign if_id_pc    = if_id_p1.pc;
  assign if_id_pc4   = if_id_p1.pc4;
  assign if_id_instr = if_id_p1.instr;
  assign if_id_valid = if_id_p1.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized control
// traffic compared against a rule-level reference model of PC and IF/ID.
module tb_if_stage;

  localparam int          AW   = 10;
  localparam int          WORDS = 1 << AW;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, flush, redirect_en;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   pc, if_id_pc, if_id_pc4, if_id_instr;
  logic          if_id_valid;

  logic [31:0] mem [WORDS];

  int checks   = 0;
  int failures = 0;

  // reference state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid;

  always #5 clk = ~clk;

  always_comb imem_rdata = mem[imem_addr];

  if_stage #(.RESET_PC(RPC), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_valid = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc,          m_pc);
    chk({tag, ".addr"},  {22'd0, imem_addr}, (m_pc / 4) % WORDS);
    chk({tag, ".ipc"},   if_id_pc,    m_ipc);
    chk({tag, ".ipc4"},  if_id_pc4,   m_ipc4);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
  endtask

  // One clock: apply controls, let the edge happen, advance model, compare.
  task automatic cycle(input string tag, input logic s, input logic f,
                       input logic r, input logic [31:0] rp);
    logic [31:0] next_pc;
    stall = s; flush = f; redirect_en = r; redirect_pc = rp;
    @(posedge clk);
    if (r)      next_pc = (rp / 4) * 4;
    else if (s) next_pc = m_pc;
    else        next_pc = m_pc + 32'd4;
    if (r || f) begin
      m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = 32'd0; m_valid = 1'b0;
    end else if (!s) begin
      m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = mem[(m_pc / 4) % WORDS]; m_valid = 1'b1;
    end
    m_pc = next_pc;
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = i;
    rst = 1'b0; stall = 0; flush = 0; redirect_en = 0; redirect_pc = 0;
    model_reset();
    #12;
    check_all("reset");

    @(negedge clk);
    rst = 1'b1;

    // free run: (0,0), (4,1), (8,2), (C,3)
    for (int i = 0; i < 4; i++) cycle("run", 0, 0, 0, 0);
    chk("run.pc10", pc, 32'h10);
    chk("run.instr3", if_id_instr, 32'd3);

    // stall three cycles at pc=0x10
    for (int i = 0; i < 3; i++) cycle("stall", 1, 0, 0, 0);
    chk("stall.pc", pc, 32'h10);
    chk("stall.ipc", if_id_pc, 32'h0C);
    cycle("resume", 0, 0, 0, 0);
    chk("resume.ipc", if_id_pc, 32'h10);
    chk("resume.pc", pc, 32'h14);

    // redirect to 0x40 from pc=0x14
    cycle("redir", 0, 0, 1, 32'h40);
    chk("redir.pc", pc, 32'h40);
    chk("redir.bubble", {31'd0, if_id_valid}, 32'd0);
    cycle("redir2", 0, 0, 0, 0);
    chk("redir2.ipc", if_id_pc, 32'h40);
    chk("redir2.valid", {31'd0, if_id_valid}, 32'd1);

    // redirect and stall together, misaligned target
    cycle("redst", 1, 0, 1, 32'h83);
    chk("redst.pc", pc, 32'h80);
    chk("redst.bubble", {31'd0, if_id_valid}, 32'd0);

    // flush under stall: pc holds, bubble
    cycle("pre", 0, 0, 0, 0);
    cycle("flst", 1, 1, 0, 0);
    chk("flst.pc", pc, 32'h84);

    // wrap at the top of the address space
    cycle("wrapr", 0, 0, 1, 32'hFFFF_FFFE);
    chk("wrapr.pc", pc, 32'hFFFF_FFFC);
    cycle("wrap", 0, 0, 0, 0);
    chk("wrap.pc", pc, 32'h0);
    chk("wrap.ipc4", if_id_pc4, 32'h0);

    // randomized traffic over random memory contents
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    for (int i = 0; i < 300; i++)
      cycle("rand", ($urandom_range(3) == 0), ($urandom_range(5) == 0),
            ($urandom_range(7) == 0), $urandom);

    // asynchronous reset mid-cycle during a stall
    cycle("pstall", 1, 0, 0, 0);
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h1234_5678;
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async.pc", pc, 32'h0);
    chk("async.valid", {31'd0, if_id_valid}, 32'd0);
    check_all("async");
    @(posedge clk);
    #1;
    check_all("inreset");

    @(negedge clk);
    rst = 1'b1;
    cycle("first", 0, 0, 0, 0);
    chk("first.ipc", if_id_pc, RPC);
    chk("first.pc", pc, RPC + 32'd4);
    cycle("second", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
